avr_fetch: RTL and testbench
============================

Name: avr_fetch

Overview:
- Instruction fetch sequencer between the synchronous program memory and the AVR decode stage.
- Issues sequential word reads and buffers the returned words in a small FIFO.
- Assembles one-word and two-word instructions (LDS/STS/JMP/CALL) and presents them to decode with a valid/ready handshake.
- Handles redirects (jump/branch/return) and skip requests (CPSE/SBRC/SBRS/SBIC/SBIS), including skipping over a two-word instruction.

Parameters:
- PAW, 11, program memory word-address width (wraps modulo 2**PAW).
- DEPTH, 3, word FIFO depth; minimum 2; 3 sustains 1 instr/cycle.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- pmem_req  output  1  program memory read request
- pmem_adr  output  PAW  read word address
- pmem_rdt  input  16  read data, valid exactly 1 cycle after pmem_req
- ins_vld  output  1  complete instruction available
- ins_rdy  input  1  decode accepts instruction
- ins_code  output  16  first instruction word
- ins_ext  output  16  second word (two-word instructions), else 0
- ins_pc  output  PAW  word address of first word
- ins_two  output  1  instruction is two-word
- jmp_vld  input  1  redirect fetch
- jmp_adr  input  PAW  redirect target
- skip  input  1  discard next instruction; sampled only on an ins_vld & ins_rdy cycle

Behaviour:
- Reset values:
  - All outputs are 0 while rst_n is low.
  - All internal state is 0: pc, FIFO count, in-flight flag, skip_pend, run flag.
- Run flag:
  - Set on the first clk edge after rst_n release.
  - pmem_req = run & (fifo_cnt + inflight - pop < DEPTH).
  - pmem_adr = pc. pc increments on each request.
- Response capture: a word returning in cycle t+1 from a request in cycle t is written into the FIFO unless jmp_vld is high in t+1.
- Two-word detect (shared function): code matches 1001_00??_????_0000 or 1001_010?_????_11??.
- ins_vld rules:
  - Asserted when the FIFO head is a one-word instruction, or is a two-word instruction with both words present.
  - ins_code, ins_ext, ins_pc and ins_two stay stable while ins_vld & ~ins_rdy.
- Pop on handshake: 1 or 2 words.
- Latency: first request in cycle 1 after reset release; first ins_vld in cycle 3.
- Throughput: with ins_rdy held high, one one-word instruction per cycle. A two-word instruction costs one extra cycle.
- Skip:
  - skip on a handshake sets skip_pend.
  - The next completed instruction (1 or 2 words) is popped internally with ins_vld held low, then skip_pend clears.
  - A skip over a two-word instruction waits for its second word.
- Redirect, in the jmp_vld cycle:
  - FIFO flushed.
  - Arriving pmem_rdt dropped.
  - skip_pend cleared.
  - pmem_req forced 1 with pmem_adr = jmp_adr; pc <= jmp_adr + 1.
  - ins_vld is 0 the following cycle. First target instruction is valid 2 cycles after jmp_vld.
- Simultaneous events:
  - Handshake + jmp_vld: the handshake completes, then the flush applies.
  - skip + jmp_vld: jmp wins and skip is ignored.
  - jmp_vld with run = 0: ignored.
- Wrap-around:
  - pc wraps from 2**PAW-1 to 0.
  - A two-word instruction at the last address takes its second word from address 0.
  - ins_pc is the address of the first word.
- FIFO full: no request issued; no word is ever lost.
- Reset mid-operation: immediate asynchronous clear; any in-flight response is ignored.

Decomposition:
- Shared package avr_pkg:
  - function is_two_word(code[15:0]).
  - Opcode constants for LDS/STS/JMP/CALL prefixes.
  - typedef for the fetched instruction record {code, ext, pc, two}.
- Sub-module avr_fetch_fifo:
  - DEPTH-entry 16-bit word FIFO with show-ahead of the 2 head entries.
  - Pop of 0/1/2 words per cycle.
  - Synchronous flush.

Test Plan:
- Sequential stream, ins_rdy=1. Memory: 0:0xE00F, 1:0x9100, 2:0x0060, 3:0x0000. Required: ins 0xE00F pc0 at cycle 3; {0x9100, 0x0060} two=1 pc1 at cycle 4; 0x0000 pc3 at cycle 6.
- Backpressure: ins_rdy=0 for 5 cycles after the first ins_vld. Required: outputs hold 0xE00F/pc0; pmem_req drops after DEPTH words; no word lost after ins_rdy rises.
- Skip over two-word instruction. Memory: 0:0x1001 (cpse), 1:0x940C, 2:0x0010, 3:0xE00F. Required: skip with 0x1001 accepted; next presented instruction is 0xE00F pc3.
- Redirect. jmp_vld with jmp_adr=0x040 while the FIFO holds 2 words. Required: flush; pmem_adr=0x040 the same cycle; the next ins_pc is 0x040 two cycles later.
- Wrap-around, PAW=11. jmp to 0x7FF containing 0x940E with word 0 = 0x0020. Required: {0x940E, 0x0020} two=1 pc 0x7FF; pmem_adr sequence 0x7FF, 0x000.
- Reset mid-operation. rst_n low during a two-word assembly. Required: all outputs 0 immediately; after release, fetch restarts at pc 0.

Source files
------------

// File: rtl/avr_pkg.sv
// Shared AVR fetch definitions: two-word opcode prefixes, the instruction record
// and the two-word detector used by the fetch stage and its bench.
package avr_pkg;

  // Prefix encodings (mask/match) of the instructions that carry a second word
  localparam logic [15:0] LdsStsMask  = 16'hFC0F;
  localparam logic [15:0] LdsStsMatch = 16'h9000;
  localparam logic [15:0] JmpCallMask  = 16'hFE0C;
  localparam logic [15:0] JmpCallMatch = 16'h940C;

  localparam logic [15:0] OpLds  = 16'h9000;
  localparam logic [15:0] OpSts  = 16'h9200;
  localparam logic [15:0] OpJmp  = 16'h940C;
  localparam logic [15:0] OpCall = 16'h940E;

  typedef struct packed {
    logic [15:0] code;
    logic [15:0] ext;
    logic [15:0] pc;
    logic        two;
  } fetch_ins_t;

  function automatic logic is_two_word(input logic [15:0] code);
    return ((code & LdsStsMask) == LdsStsMatch) || ((code & JmpCallMask) == JmpCallMatch);
  endfunction

endpackage

// File: rtl/avr_fetch_fifo.sv
// Shift-register word FIFO: head at index 0, two-entry show-ahead, pop of 0/1/2 words
// per cycle (a pop may consume the word pushed in the same cycle), synchronous flush.
module avr_fetch_fifo #(
  parameter int unsigned Depth = 3,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [15:0]     wdata_i,
  input  logic [1:0]      pop_i,
  output logic [15:0]     head0_o,
  output logic [15:0]     head1_o,
  output logic [CntW-1:0] cnt_o
);

  logic [15:0]     mem_q [Depth];
  logic [15:0]     mem_d [Depth];
  logic [15:0]     tmp   [Depth+2];
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < int'(Depth) + 2; i++) begin
      tmp[i] = (i < int'(Depth)) ? mem_q[i] : 16'h0000;
      if (push_i && i == int'(cnt_q)) tmp[i] = wdata_i;
    end
    for (int i = 0; i < int'(Depth); i++) begin
      mem_d[i] = tmp[i + int'(pop_i)];
    end
    cnt_d = flush_i ? '0 : CntW'(int'(cnt_q) + int'(push_i) - int'(pop_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= mem_d[i];
    end
  end

  assign head0_o = mem_q[0];
  assign head1_o = mem_q[1];
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/avr_fetch.sv
// AVR instruction fetch: sequential program-memory reads into a word FIFO, one/two-word
// instruction assembly toward decode, redirects and skip-next handling.
module avr_fetch
  import avr_pkg::*;
#(
  parameter int unsigned PAW   = 11,
  parameter int unsigned DEPTH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           pmem_req,
  output logic [PAW-1:0] pmem_adr,
  input  logic [15:0]    pmem_rdt,
  output logic           ins_vld,
  input  logic           ins_rdy,
  output logic [15:0]    ins_code,
  output logic [15:0]    ins_ext,
  output logic [PAW-1:0] ins_pc,
  output logic           ins_two,
  input  logic           jmp_vld,
  input  logic [PAW-1:0] jmp_adr,
  input  logic           skip
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic            run_q, inflight_q, skip_pend_q;
  logic [PAW-1:0]  pc_q, head_pc_q;
  logic [15:0]     head0, head1, second;
  logic [CntW-1:0] cnt;
  logic [1:0]      pop;
  logic            jmp_act, push, head_two, have2, complete, hs, skip_pop;

  always_comb begin
    jmp_act  = jmp_vld & run_q;
    push     = inflight_q & ~jmp_act;
    head_two = is_two_word(head0);
    // The word arriving this cycle may complete a two-word instruction directly
    have2    = (int'(cnt) >= 2) | ((int'(cnt) == 1) & inflight_q);
    second   = (int'(cnt) >= 2) ? head1 : pmem_rdt;
    complete = (cnt != '0) & (~head_two | have2);
    ins_vld  = complete & ~skip_pend_q;
    hs       = ins_vld & ins_rdy;
    skip_pop = complete & skip_pend_q;
    pop      = 2'd0;
    if (hs || skip_pop) pop = head_two ? 2'd2 : 2'd1;
    // Request only if the returning word is guaranteed a free slot
    pmem_req = run_q & (jmp_act |
               ((int'(cnt) + int'(inflight_q) - int'(pop)) < int'(DEPTH)));
    pmem_adr = jmp_act ? jmp_adr : pc_q;
    ins_code = head0;
    ins_two  = head_two;
    ins_ext  = head_two ? second : 16'h0000;
    ins_pc   = head_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      inflight_q  <= 1'b0;
      skip_pend_q <= 1'b0;
      pc_q        <= '0;
      head_pc_q   <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= pmem_req;
      if (jmp_act)       pc_q <= jmp_adr + PAW'(1);
      else if (pmem_req) pc_q <= pc_q + PAW'(1);
      head_pc_q <= jmp_act ? jmp_adr : head_pc_q + PAW'(pop);
      if (jmp_act)       skip_pend_q <= 1'b0;
      else if (hs && skip) skip_pend_q <= 1'b1;
      else if (skip_pop) skip_pend_q <= 1'b0;
    end
  end

  avr_fetch_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (jmp_act),
    .push_i  (push),
    .wdata_i (pmem_rdt),
    .pop_i   (pop),
    .head0_o (head0),
    .head1_o (head1),
    .cnt_o   (cnt)
  );

endmodule

// File: tb/tb_avr_fetch.sv
// Directed bench for avr_fetch with a one-cycle-latency program memory model.
module tb_avr_fetch;
  import avr_pkg::*;

  localparam int unsigned PAW   = 11;
  localparam int unsigned DEPTH = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           pmem_req;
  logic [PAW-1:0] pmem_adr;
  logic [15:0]    pmem_rdt = 16'h0000;
  logic           ins_vld;
  logic           ins_rdy = 1'b0;
  logic [15:0]    ins_code, ins_ext;
  logic [PAW-1:0] ins_pc;
  logic           ins_two;
  logic           jmp_vld = 1'b0;
  logic [PAW-1:0] jmp_adr = '0;
  logic           skip = 1'b0;

  logic [15:0] mem [2**PAW];
  fetch_ins_t  got;
  int          total = 0;
  int          bad = 0;

  avr_fetch #(
    .PAW   (PAW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pmem_req (pmem_req),
    .pmem_adr (pmem_adr),
    .pmem_rdt (pmem_rdt),
    .ins_vld  (ins_vld),
    .ins_rdy  (ins_rdy),
    .ins_code (ins_code),
    .ins_ext  (ins_ext),
    .ins_pc   (ins_pc),
    .ins_two  (ins_two),
    .jmp_vld  (jmp_vld),
    .jmp_adr  (jmp_adr),
    .skip     (skip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pmem_req) pmem_rdt <= mem[pmem_adr];
    else          pmem_rdt <= 16'hDEAD;
  end

  assign got = '{code: ins_code, ext: ins_ext, pc: 16'(ins_pc), two: ins_two};

  function automatic fetch_ins_t mk(input logic [15:0] c, input logic [15:0] e,
                                    input logic [15:0] p, input logic t);
    fetch_ins_t r;
    r.code = c;
    r.ext  = e;
    r.pc   = p;
    r.two  = t;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2**PAW; i++) mem[i] = 16'h0000;
  endtask

  // Leaves the bench in cycle 0 (first cycle after release, run flag still clear)
  task automatic do_reset();
    rst_n   = 1'b0;
    ins_rdy = 1'b0;
    jmp_vld = 1'b0;
    jmp_adr = '0;
    skip    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = 16'hE00F;
    rst_n   = 1'b0;
    jmp_vld = 1'b1;
    jmp_adr = 11'h155;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if ({pmem_req, pmem_adr, ins_vld, got} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b adr=%h vld=%b rec=%h, want all 0",
               pmem_req, pmem_adr, ins_vld, got);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (pmem_req !== 1'b0 || pmem_adr !== 11'h000) begin
      bad++;
      $display("FAIL jmp_before_run: got req=%b adr=%h, want req=0 adr=000", pmem_req, pmem_adr);
    end
    jmp_vld = 1'b0;
    tick();
    #1;
    total++;
    if (pmem_req !== 1'b1 || pmem_adr !== 11'h000 || ins_vld !== 1'b0) begin
      bad++;
      $display("FAIL first_request: got req=%b adr=%h vld=%b, want req=1 adr=000 vld=0",
               pmem_req, pmem_adr, ins_vld);
    end
  endtask

  task automatic test_sequential();
    logic       ev [8];
    fetch_ins_t er [8];
    clear_mem();
    mem[0] = 16'hE00F; mem[1] = 16'h9100; mem[2] = 16'h0060; mem[3] = 16'h0000;
    ev = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) er[c] = '0;
    er[3] = mk(16'hE00F, 16'h0000, 16'd0, 1'b0);
    er[4] = mk(16'h9100, 16'h0060, 16'd1, 1'b1);
    er[6] = mk(16'h0000, 16'h0000, 16'd3, 1'b0);
    er[7] = mk(16'h0000, 16'h0000, 16'd4, 1'b0);
    do_reset();
    ins_rdy = 1'b1;
    for (int c = 1; c < 8; c++) begin
      tick();
      #1;
      total++;
      if (pmem_req !== 1'b1 || pmem_adr !== 11'(c - 1)) begin
        bad++;
        $display("FAIL seq_req c%0d: got req=%b adr=%h, want req=1 adr=%h",
                 c, pmem_req, pmem_adr, 11'(c - 1));
      end
      total++;
      if (ins_vld !== ev[c] || (ev[c] && got !== er[c])) begin
        bad++;
        $display("FAIL seq_ins c%0d: got vld=%b rec=%h, want vld=%b rec=%h",
                 c, ins_vld, got, ev[c], er[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    clear_mem();
    mem[0] = 16'hE00F;
    for (int i = 1; i < 8; i++) mem[i] = 16'(i);
    do_reset();
    for (int c = 1; c < 8; c++) begin
      tick();
      #1;
      if (pmem_req === 1'b1) nreq++;
      if (c >= 3) begin
        total++;
        if (ins_vld !== 1'b1 || got !== mk(16'hE00F, 16'h0000, 16'd0, 1'b0)) begin
          bad++;
          $display("FAIL bp_hold c%0d: got vld=%b rec=%h, want vld=1 E00F pc0", c, ins_vld, got);
        end
      end
    end
    total++;
    if (nreq != int'(DEPTH)) begin
      bad++;
      $display("FAIL bp_req_count: got %0d, want %0d", nreq, DEPTH);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      ins_rdy = 1'b1;
      #1;
      total++;
      if (ins_vld !== 1'b1 || got !== mk(mem[k], 16'h0000, 16'(k), 1'b0)) begin
        bad++;
        $display("FAIL bp_drain %0d: got vld=%b rec=%h, want vld=1 code=%h pc=%0d",
                 k, ins_vld, got, mem[k], k);
      end
    end
  endtask

  task automatic test_skip();
    int  c = 4;
    logic seen = 1'b0;
    clear_mem();
    mem[0] = 16'h1001; mem[1] = 16'h940C; mem[2] = 16'h0010; mem[3] = 16'hE00F;
    do_reset();
    ins_rdy = 1'b1;
    repeat (3) tick();
    skip = 1'b1;
    #1;
    total++;
    if (ins_vld !== 1'b1 || got !== mk(16'h1001, 16'h0000, 16'd0, 1'b0)) begin
      bad++;
      $display("FAIL skip_cpse: got vld=%b rec=%h, want vld=1 1001 pc0", ins_vld, got);
    end
    tick();
    skip = 1'b0;
    #1;
    while (!seen && c < 12) begin
      if (ins_vld === 1'b1) seen = 1'b1;
      else begin
        tick();
        #1;
        c++;
      end
    end
    total++;
    if (!seen || c != 6 || got !== mk(16'hE00F, 16'h0000, 16'd3, 1'b0)) begin
      bad++;
      $display("FAIL skip_next: got seen=%b cycle=%0d rec=%h, want cycle 6 E00F pc3",
               seen, c, got);
    end
  endtask

  task automatic test_redirect();
    clear_mem();
    mem[0] = 16'hE00F; mem[1] = 16'h0001; mem[2] = 16'h0002;
    mem[11'h040] = 16'hC123; mem[11'h041] = 16'h0041;
    do_reset();
    repeat (4) tick();
    jmp_vld = 1'b1;
    jmp_adr = 11'h040;
    #1;
    total++;
    if (pmem_req !== 1'b1 || pmem_adr !== 11'h040) begin
      bad++;
      $display("FAIL jmp_req: got req=%b adr=%h, want req=1 adr=040", pmem_req, pmem_adr);
    end
    tick();
    jmp_vld = 1'b0;
    ins_rdy = 1'b1;
    #1;
    total++;
    if (ins_vld !== 1'b0 || pmem_adr !== 11'h041) begin
      bad++;
      $display("FAIL jmp_flush: got vld=%b adr=%h, want vld=0 adr=041", ins_vld, pmem_adr);
    end
    tick();
    #1;
    total++;
    if (ins_vld !== 1'b1 || got !== mk(16'hC123, 16'h0000, 16'h0040, 1'b0)) begin
      bad++;
      $display("FAIL jmp_target: got vld=%b rec=%h, want vld=1 C123 pc040", ins_vld, got);
    end
    tick();
    #1;
    total++;
    if (ins_vld !== 1'b1 || got !== mk(16'h0041, 16'h0000, 16'h0041, 1'b0)) begin
      bad++;
      $display("FAIL jmp_next: got vld=%b rec=%h, want vld=1 0041 pc041", ins_vld, got);
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[11'h7FF] = 16'h940E; mem[0] = 16'h0020; mem[1] = 16'h0001;
    do_reset();
    ins_rdy = 1'b1;
    tick();
    jmp_vld = 1'b1;
    jmp_adr = 11'h7FF;
    #1;
    total++;
    if (pmem_req !== 1'b1 || pmem_adr !== 11'h7FF) begin
      bad++;
      $display("FAIL wrap_adr0: got req=%b adr=%h, want req=1 adr=7FF", pmem_req, pmem_adr);
    end
    tick();
    jmp_vld = 1'b0;
    #1;
    total++;
    if (pmem_req !== 1'b1 || pmem_adr !== 11'h000 || ins_vld !== 1'b0) begin
      bad++;
      $display("FAIL wrap_adr1: got req=%b adr=%h vld=%b, want req=1 adr=000 vld=0",
               pmem_req, pmem_adr, ins_vld);
    end
    tick();
    #1;
    total++;
    if (ins_vld !== 1'b1 || got !== mk(16'h940E, 16'h0020, 16'h07FF, 1'b1)) begin
      bad++;
      $display("FAIL wrap_call: got vld=%b rec=%h, want vld=1 940E/0020 pc7FF two", ins_vld, got);
    end
    repeat (2) tick();
    #1;
    total++;
    if (ins_vld !== 1'b1 || got !== mk(16'h0001, 16'h0000, 16'h0001, 1'b0)) begin
      bad++;
      $display("FAIL wrap_next: got vld=%b rec=%h, want vld=1 0001 pc001", ins_vld, got);
    end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = 16'hE00F; mem[1] = 16'h9200; mem[2] = 16'h0070;
    do_reset();
    ins_rdy = 1'b1;
    repeat (4) tick();
    ins_rdy = 1'b0;
    #1;
    total++;
    if (ins_vld !== 1'b1 || got !== mk(16'h9200, 16'h0070, 16'd1, 1'b1)) begin
      bad++;
      $display("FAIL mid_sts: got vld=%b rec=%h, want vld=1 9200/0070 pc1 two", ins_vld, got);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({pmem_req, pmem_adr, ins_vld, got} !== '0) begin
      bad++;
      $display("FAIL mid_async_clear: got req=%b adr=%h vld=%b rec=%h, want all 0",
               pmem_req, pmem_adr, ins_vld, got);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    ins_rdy = 1'b1;
    tick();
    #1;
    total++;
    if (pmem_req !== 1'b1 || pmem_adr !== 11'h000) begin
      bad++;
      $display("FAIL mid_restart: got req=%b adr=%h, want req=1 adr=000", pmem_req, pmem_adr);
    end
    repeat (2) tick();
    #1;
    total++;
    if (ins_vld !== 1'b1 || got !== mk(16'hE00F, 16'h0000, 16'd0, 1'b0)) begin
      bad++;
      $display("FAIL mid_first: got vld=%b rec=%h, want vld=1 E00F pc0", ins_vld, got);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_skip();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
